// File: rtl/tick_stopwatch_pkg.sv
// Shared definitions for the tick_stopwatch slice: control FSM states,
// BCD digit width and the per-digit roll-over limits.
package stopwatch_pkg;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // Largest value of a decimal "ones" digit.
  localparam logic [BCD_W-1:0] DIGIT_MAX_ONES = 4'd9;

  // Largest value of a "tens" digit for a 00..59 field.
  localparam logic [BCD_W-1:0] DIGIT_MAX_TENS = 4'd5;

  // Run/pause control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

endpackage

// File: rtl/tick_stopwatch_bcd_digit.sv
// One BCD digit of the stopwatch chain. Counts 0..i_limit on i_inc and
// wraps to 0; o_carry is combinational so a whole chain ripples in a cycle.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [BCD_W-1:0] i_limit,
  output logic [BCD_W-1:0] o_q,
  output logic             o_carry
);

  logic [BCD_W-1:0] r_q;
  logic             w_at_limit;

  assign w_at_limit = (r_q == i_limit);
  assign o_carry    = i_inc && w_at_limit;
  assign o_q        = r_q;

  // Digit register: reset/clear to zero, otherwise increment with wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= 4'd0;
    end else if (i_clr) begin
      r_q <= 4'd0;
    end else if (i_inc) begin
      if (w_at_limit) begin
        r_q <= 4'd0;
      end else begin
        r_q <= r_q + 4'd1;
      end
    end else begin
      r_q <= r_q;
    end
  end

endmodule

// File: rtl/tick_stopwatch.sv
// tick_stopwatch: counts one-second ticks from an upstream prescaler into
// MM:SS BCD digits, gated by a start/stop/clear FSM. A sticky overflow flag
// marks a wrap past the last minute value.
// Optional lap-freeze display is built when TICK_STOPWATCH_LAP_EN is defined.
// SEC_LIMIT / MIN_LIMIT are expected to end in the digit 9 (e.g. 59); the
// tens digit limit is derived from them.
module tick_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int SEC_LIMIT = 59,
  parameter int MIN_LIMIT = 59
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_in,
  input  logic       i_start_stop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic [3:0] o_disp_sec_ones,
  output logic [3:0] o_disp_sec_tens,
  output logic [3:0] o_disp_min_ones,
  output logic [3:0] o_disp_min_tens,
  output logic       o_running,
  output logic       o_lap_active,
  output logic       o_overflow
);

  localparam logic [BCD_W-1:0] SEC_TENS_LIM = 4'(SEC_LIMIT / 10);
  localparam logic [BCD_W-1:0] MIN_TENS_LIM = 4'(MIN_LIMIT / 10);

  sw_state_e        r_state;
  sw_state_e        w_state_nxt;
  logic             r_running;
  logic             r_overflow;
  logic             w_cnt_en;
  logic             w_c0;
  logic             w_c1;
  logic             w_c2;
  logic             w_c3;
  logic [BCD_W-1:0] w_sec_ones;
  logic [BCD_W-1:0] w_sec_tens;
  logic [BCD_W-1:0] w_min_ones;
  logic [BCD_W-1:0] w_min_tens;

  // Next-state logic: clear dominates, start_stop toggles RUN/PAUSE.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = i_start_stop ? RUN   : IDLE;
        RUN:     w_state_nxt = i_start_stop ? PAUSE : RUN;
        PAUSE:   w_state_nxt = i_start_stop ? RUN   : PAUSE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register with running flag updated on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  // Ticks count only while currently in RUN; a clear in the same cycle wins.
  assign w_cnt_en = (r_state == RUN) && i_tick_in && !i_clear;

  bcd_digit u_sec_ones (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_clear),
    .i_inc   (w_cnt_en),
    .i_limit (DIGIT_MAX_ONES),
    .o_q     (w_sec_ones),
    .o_carry (w_c0)
  );

  bcd_digit u_sec_tens (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_clear),
    .i_inc   (w_c0),
    .i_limit (SEC_TENS_LIM),
    .o_q     (w_sec_tens),
    .o_carry (w_c1)
  );

  bcd_digit u_min_ones (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_clear),
    .i_inc   (w_c1),
    .i_limit (DIGIT_MAX_ONES),
    .o_q     (w_min_ones),
    .o_carry (w_c2)
  );

  bcd_digit u_min_tens (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_clear),
    .i_inc   (w_c2),
    .i_limit (MIN_TENS_LIM),
    .o_q     (w_min_tens),
    .o_carry (w_c3)
  );

  // Sticky overflow: set when the top digit wraps, cleared only by clear/reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_overflow <= 1'b0;
    end else if (w_c3) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign o_running  = r_running;
  assign o_overflow = r_overflow;

`ifdef TICK_STOPWATCH_LAP_EN
  logic             r_lap_active;
  logic [BCD_W-1:0] r_snap_sec_ones;
  logic [BCD_W-1:0] r_snap_sec_tens;
  logic [BCD_W-1:0] r_snap_min_ones;
  logic [BCD_W-1:0] r_snap_min_tens;
  logic             w_lap_ok;

  // Lap is honoured only outside IDLE and never alongside a clear.
  assign w_lap_ok = i_lap && !i_clear && ((r_state == RUN) || (r_state == PAUSE));

  // Lap toggle: first press snapshots the pre-increment live time, second releases.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lap_active    <= 1'b0;
      r_snap_sec_ones <= 4'd0;
      r_snap_sec_tens <= 4'd0;
      r_snap_min_ones <= 4'd0;
      r_snap_min_tens <= 4'd0;
    end else if (i_clear) begin
      r_lap_active    <= 1'b0;
      r_snap_sec_ones <= r_snap_sec_ones;
      r_snap_sec_tens <= r_snap_sec_tens;
      r_snap_min_ones <= r_snap_min_ones;
      r_snap_min_tens <= r_snap_min_tens;
    end else if (w_lap_ok && !r_lap_active) begin
      r_lap_active    <= 1'b1;
      r_snap_sec_ones <= w_sec_ones;
      r_snap_sec_tens <= w_sec_tens;
      r_snap_min_ones <= w_min_ones;
      r_snap_min_tens <= w_min_tens;
    end else if (w_lap_ok) begin
      r_lap_active    <= 1'b0;
      r_snap_sec_ones <= r_snap_sec_ones;
      r_snap_sec_tens <= r_snap_sec_tens;
      r_snap_min_ones <= r_snap_min_ones;
      r_snap_min_tens <= r_snap_min_tens;
    end else begin
      r_lap_active    <= r_lap_active;
      r_snap_sec_ones <= r_snap_sec_ones;
      r_snap_sec_tens <= r_snap_sec_tens;
      r_snap_min_ones <= r_snap_min_ones;
      r_snap_min_tens <= r_snap_min_tens;
    end
  end

  // Display selects between two register banks; no input reaches the outputs.
  assign o_disp_sec_ones = r_lap_active ? r_snap_sec_ones : w_sec_ones;
  assign o_disp_sec_tens = r_lap_active ? r_snap_sec_tens : w_sec_tens;
  assign o_disp_min_ones = r_lap_active ? r_snap_min_ones : w_min_ones;
  assign o_disp_min_tens = r_lap_active ? r_snap_min_tens : w_min_tens;
  assign o_lap_active    = r_lap_active;
`else
  logic w_lap_unused;

  // Lap has no function in this build.
  assign w_lap_unused    = i_lap;
  assign o_disp_sec_ones = w_sec_ones;
  assign o_disp_sec_tens = w_sec_tens;
  assign o_disp_min_ones = w_min_ones;
  assign o_disp_min_tens = w_min_tens;
  assign o_lap_active    = 1'b0;
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed self-checking bench for tick_stopwatch. Expected lap behaviour
// follows TICK_STOPWATCH_LAP_EN as defined for the build.
module tb_tick_stopwatch;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       ss;
  logic       clr;
  logic       lap;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       lap_active;
  logic       overflow;
  logic [15:0] disp;

  int n_checks;
  int n_errors;

  tick_stopwatch dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_tick_in       (tick),
    .i_start_stop    (ss),
    .i_clear         (clr),
    .i_lap           (lap),
    .o_disp_sec_ones (sec_ones),
    .o_disp_sec_tens (sec_tens),
    .o_disp_min_ones (min_ones),
    .o_disp_min_tens (min_tens),
    .o_running       (running),
    .o_lap_active    (lap_active),
    .o_overflow      (overflow)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus; outputs are stable #1 after the edge.
  task automatic cyc(input logic a_ss, input logic a_clr, input logic a_lap,
                     input logic a_tick, input logic a_rst);
    @(negedge clk);
    ss = a_ss; clr = a_clr; lap = a_lap; tick = a_tick; rst = a_rst;
    @(posedge clk);
    #1;
    ss = 1'b0; clr = 1'b0; lap = 1'b0; tick = 1'b0; rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (disp !== 16'h0000) begin n_errors++; $display("FAIL reset_disp: got %h expected 0000", disp); end
    n_checks++;
    if (running !== 1'b0) begin n_errors++; $display("FAIL reset_running: got %b expected 0", running); end
    n_checks++;
    if (lap_active !== 1'b0) begin n_errors++; $display("FAIL reset_lap_active: got %b expected 0", lap_active); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    ticks(2);
    n_checks++;
    if (disp !== 16'h0000) begin n_errors++; $display("FAIL idle_ignores_tick: got %h expected 0000", disp); end
  endtask

  task automatic test_basic_count;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (running !== 1'b1) begin n_errors++; $display("FAIL start_running: got %b expected 1", running); end
    ticks(3);
    n_checks++;
    if (disp !== 16'h0003) begin n_errors++; $display("FAIL basic_disp: got %h expected 0003", disp); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_carry;
    ticks(56);
    n_checks++;
    if (disp !== 16'h0059) begin n_errors++; $display("FAIL pre_carry: got %h expected 0059", disp); end
    ticks(1);
    n_checks++;
    if (disp !== 16'h0100) begin n_errors++; $display("FAIL sec_carry: got %h expected 0100", disp); end
    ticks(3539);
    n_checks++;
    if (disp !== 16'h5959 || overflow !== 1'b0) begin
      n_errors++; $display("FAIL at_5959: got %h ovf %b expected 5959 ovf 0", disp, overflow);
    end
    ticks(1);
    n_checks++;
    if (disp !== 16'h0000 || overflow !== 1'b1) begin
      n_errors++; $display("FAIL wrap: got %h ovf %b expected 0000 ovf 1", disp, overflow);
    end
    ticks(1);
    n_checks++;
    if (disp !== 16'h0001 || overflow !== 1'b1) begin
      n_errors++; $display("FAIL sticky_ovf: got %h ovf %b expected 0001 ovf 1", disp, overflow);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (disp !== 16'h0000 || overflow !== 1'b0 || running !== 1'b0) begin
      n_errors++; $display("FAIL clear: got %h ovf %b run %b expected 0000 0 0", disp, overflow, running);
    end
    ticks(1);
    n_checks++;
    if (disp !== 16'h0000) begin n_errors++; $display("FAIL clear_to_idle: got %h expected 0000", disp); end
  endtask

  task automatic test_ss_tick;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(5);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (disp !== 16'h0006 || running !== 1'b0) begin
      n_errors++; $display("FAIL ss_tick_run: got %h run %b expected 0006 0", disp, running);
    end
    ticks(4);
    n_checks++;
    if (disp !== 16'h0006) begin n_errors++; $display("FAIL pause_hold: got %h expected 0006", disp); end
    // resume and pause with a tick in the same cycle: tick not counted
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (disp !== 16'h0006 || running !== 1'b1) begin
      n_errors++; $display("FAIL ss_tick_pause: got %h run %b expected 0006 1", disp, running);
    end
  endtask

  task automatic test_clear_ss;
    ticks(124);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (disp !== 16'h0210 || running !== 1'b0) begin
      n_errors++; $display("FAIL pause_0210: got %h run %b expected 0210 0", disp, running);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (disp !== 16'h0000 || running !== 1'b0) begin
      n_errors++; $display("FAIL clear_ss: got %h run %b expected 0000 0", disp, running);
    end
    ticks(1);
    n_checks++;
    if (disp !== 16'h0000) begin n_errors++; $display("FAIL clear_ss_idle: got %h expected 0000", disp); end
  endtask

  task automatic test_lap;
    logic [15:0] exp_hold;
    logic        exp_la;
    logic [15:0] exp_snap;
`ifdef TICK_STOPWATCH_LAP_EN
    exp_hold = 16'h0010; exp_la = 1'b1; exp_snap = 16'h0003;
`else
    exp_hold = 16'h0015; exp_la = 1'b0; exp_snap = 16'h0004;
`endif
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (lap_active !== 1'b0) begin n_errors++; $display("FAIL lap_idle: got %b expected 0", lap_active); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    n_checks++;
    if (disp !== exp_hold || lap_active !== exp_la) begin
      n_errors++; $display("FAIL lap_hold: got %h la %b expected %h la %b", disp, lap_active, exp_hold, exp_la);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (disp !== 16'h0015 || lap_active !== 1'b0) begin
      n_errors++; $display("FAIL lap_release: got %h la %b expected 0015 la 0", disp, lap_active);
    end
    // lap together with a tick: snapshot is the pre-increment value
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (disp !== exp_snap || lap_active !== exp_la) begin
      n_errors++; $display("FAIL lap_tick: got %h la %b expected %h la %b", disp, lap_active, exp_snap, exp_la);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (disp !== 16'h0000 || lap_active !== 1'b0) begin
      n_errors++; $display("FAIL lap_clear: got %h la %b expected 0000 la 0", disp, lap_active);
    end
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(754);
    n_checks++;
    if (disp !== 16'h1234 || running !== 1'b1) begin
      n_errors++; $display("FAIL pre_rst_1234: got %h run %b expected 1234 1", disp, running);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (disp !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0 || lap_active !== 1'b0) begin
      n_errors++; $display("FAIL mid_rst: got %h run %b ovf %b la %b expected 0000 0 0 0",
                           disp, running, overflow, lap_active);
    end
    ticks(2);
    n_checks++;
    if (disp !== 16'h0000) begin n_errors++; $display("FAIL rst_idle: got %h expected 0000", disp); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (disp !== 16'h0000 || running !== 1'b1) begin
      n_errors++; $display("FAIL idle_ss_tick: got %h run %b expected 0000 1", disp, running);
    end
    ticks(1);
    n_checks++;
    if (disp !== 16'h0001) begin n_errors++; $display("FAIL after_idle_ss: got %h expected 0001", disp); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; tick = 1'b0; ss = 1'b0; clr = 1'b0; lap = 1'b0;
    test_reset;
    test_basic_count;
    test_carry;
    test_ss_tick;
    test_clear_ss;
    test_lap;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch.md
# tick_stopwatch

- Downstream consumer of the modulo-N counter's terminal-count pulse.
- Treats each `tc` pulse as a one-second tick and accumulates elapsed time as four BCD digits (MM:SS, 00:00–59:59).
- A start/stop/clear control FSM gates the accumulation, and an optional lap-freeze function holds the displayed time.
- Sits between the prescaler counter and the display/driver logic.

## Interface
Parameters:
- `SEC_LIMIT`, 59: last value of the seconds field before it rolls to 00.
- `MIN_LIMIT`, 59: last value of the minutes field before wrap and overflow.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `tick_in`  input  1  one-cycle pulse from upstream counter `tc`.
- `start_stop`  input  1  one-cycle command pulse; toggles run/pause.
- `clear`  input  1  one-cycle command pulse; zeroes time and returns to idle.
- `lap`  input  1  one-cycle command pulse; toggles display freeze (macro-dependent).
- `disp_sec_ones`  output  4  BCD digit 0–9.
- `disp_sec_tens`  output  4  BCD digit 0–5.
- `disp_min_ones`  output  4  BCD digit 0–9.
- `disp_min_tens`  output  4  BCD digit 0–5.
- `running`  output  1  high while in RUN.
- `lap_active`  output  1  high while the display is frozen.
- `overflow`  output  1  sticky; set on wrap past 59:59.

## Operation
FSM states and transitions:
- IDLE: time is 00:00.
  - `start_stop` → RUN.
- RUN: each `tick_in` increments the time.
  - `start_stop` → PAUSE.
- PAUSE: ticks are ignored.
  - `start_stop` → RUN.
- Any state, on `clear` → IDLE. Clear also:
  - zeroes all digits,
  - clears `overflow`,
  - releases the freeze.

Command priority, evaluated per cycle: `rst` > `clear` > `start_stop` > `lap` > `tick_in`.
- A lower-priority event in the same cycle is ignored only when it conflicts with a higher one.
- `clear` + `start_stop` in the same cycle: clear wins; `start_stop` is dropped.
- `tick_in` + `start_stop` in IDLE: no count; the state is still IDLE at that edge.
- `tick_in` + `start_stop` in RUN: tick is counted, and the state moves to PAUSE.
- `tick_in` + `lap` in RUN: tick is counted; the latched snapshot is the pre-increment value.

Increment arithmetic is BCD ripple:
- `sec_ones` 9 → 0 carries into `sec_tens`.
- `sec_tens` 5 → 0 carries into minutes.
- Minutes follow the same pattern.
- A tick at 59:59 produces 00:00 and sets `overflow`. Counting continues.
- Non-BCD codes are never produced.

## Timing
- All outputs are registered.
- Tick latency: a tick sampled at edge k appears on `disp_*` after edge k (visible in cycle k+1).
- `running` updates on the same edge as the state change.
- Reset values:
  - all `disp_*` = 0,
  - `running` = 0,
  - `lap_active` = 0,
  - `overflow` = 0,
  - state = IDLE.
- Reset asserted mid-count: on the next edge everything returns to reset values. No partial carry survives.
- `tick_in` is expected to be a single-cycle pulse. A level held high for M cycles counts M times in RUN.

## Configuration
Macro `TICK_STOPWATCH_LAP_EN`.

When defined:
- `lap` is honoured in RUN and PAUSE and ignored in IDLE.
- First `lap`: latches the live time into display registers and sets `lap_active`. The display holds while internal counting continues.
- Second `lap`: releases the freeze. The display shows live time on the next cycle.
- `clear` releases the freeze.

When undefined:
- `lap` is ignored.
- `lap_active` is tied 0.
- `disp_*` always show live time.
- No snapshot registers are built.

## Structure
Shared package `stopwatch_pkg` holds:
- FSM state enum: IDLE, RUN, PAUSE.
- BCD width constant: 4.
- Digit limit constants: 9 and 5.

Sub-module `bcd_digit` holds one BCD digit:
- Ports: `clk`, `rst`, `clr`, `inc`, `limit`, `q`, `carry`.
- `carry` is combinational, equal to `inc && q == limit`.
- Four instances are chained.
- The top level holds the FSM, the overflow flag and the optional lap registers.

## Test plan
- Reset, then `start_stop`, then 3 ticks → display 00:03, `running`=1, `overflow`=0.
- Preload to 00:59 via ticks, then 1 tick → 01:00. From 59:59, 1 tick → 00:00, `overflow`=1. A following `clear` → 00:00, `overflow`=0, state IDLE.
- RUN at 00:05, `start_stop` + `tick_in` in the same cycle → 00:06 and `running`=0. 4 further ticks → still 00:06.
- `clear` + `start_stop` in the same cycle from PAUSE at 02:10 → 00:00, `running`=0.
- With `TICK_STOPWATCH_LAP_EN`: RUN at 00:10, `lap`, then 5 ticks → display 00:10, `lap_active`=1. Second `lap` → display 00:15 next cycle. Without the macro, the same stimulus → display 00:15 throughout, `lap_active`=0.
- Assert `rst` for 1 cycle at 12:34 in RUN → all outputs 0, IDLE. 2 ticks without `start_stop` → still 00:00.
